div_seq: RTL and testbench
==========================

Name: div_seq

Overview:
- Iterative 32-bit signed/unsigned divider sequencer for DIV/DIVU.
- Produces the 64-bit {HI, LO} result that the write-back path commits to the HI/LO register pair: remainder goes to HI, quotient goes to LO.
- Sits beside the EX stage. EX holds start_i and stalls the pipeline until ready_o is asserted.
- Radix-2 restoring algorithm, one quotient bit per cycle, FSM-controlled.

Parameters:
- WIDTH, 32, operand width. Result width is 2*WIDTH.
- CNT_W, 6, iteration-counter width. Must hold the value WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- start_i  input  1  divide request. Held high by EX until ready_o is seen.
- annul_i  input  1  cancel request (flush/exception). Aborts any operation in progress.
- signed_div_i  input  1  1 = DIV (signed), 0 = DIVU.
- opdata1_i  input  WIDTH  dividend.
- opdata2_i  input  WIDTH  divisor.
- result_o  output  2*WIDTH  {remainder, quotient}.
- ready_o  output  1  result valid.

Behaviour:
- Reset: rst low, asynchronous.
  - state=FREE, cnt=0, working register=0, result_o=0, ready_o=0.
  - Applies in any state, including mid-operation. No partial result survives reset.
- States: FREE, BYZERO, ON, END.
- FREE
  - start_i=1 and annul_i=0, opdata2_i=0: go to BYZERO.
  - start_i=1 and annul_i=0, opdata2_i≠0: go to ON.
    - Latch magnitudes: in signed mode, negate any negative operand; unsigned mode uses operands as-is.
    - Latch sign info: dividend sign, and sign of the quotient (XOR of operand signs; signed mode only).
    - Clear cnt to 0. Working register = {WIDTH'b0, |dividend|, 1'b0}.
  - Otherwise: stay in FREE. ready_o=0, result_o=0.
- BYZERO: one cycle. Result = 0. Go to END.
- ON, annul_i=1: go to FREE. result_o=0, ready_o=0. No result is produced.
- ON, cnt<WIDTH: one restoring step per cycle, then cnt+1.
  - Trial: upper half minus |divisor|, computed at WIDTH+1 bits.
  - Borrow: shift working register left 1, inserting quotient bit 0.
  - No borrow: replace upper half with the difference, then shift left 1, inserting quotient bit 1.
- ON, cnt==WIDTH: finalize and go to END.
  - Quotient negated if signed and the quotient sign is set.
  - Remainder negated if signed and the dividend was negative.
  - Remainder taken from the upper half with the final shift undone.
- END
  - ready_o=1. result_o={remainder, quotient}.
  - Held stable while start_i=1.
  - When start_i=0: go to FREE; ready_o and result_o return to 0 on that edge.
- Operands are sampled only on the FREE→ON/BYZERO edge. Later changes to opdata are ignored.
- Latency, normal case: ready_o rises at the 34th rising edge after the edge that samples start in FREE (1 load + 32 iterations + 1 finalize).
- Latency, divide-by-zero: ready_o rises at the 2nd such edge.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient 0x80000000, remainder 0 (two's-complement wrap). No trap.
- Simultaneous start_i and annul_i in FREE: annul wins; stay in FREE.
- annul_i in BYZERO or END: ignored. END exits only when start_i drops.

Optional Feature:
- Macro: DIV_ZERO_FLAG_EN.
- Defined:
  - Extra output div_zero_o (1 bit).
  - div_zero_o=1 alongside ready_o whenever the operation went through BYZERO; otherwise 0.
  - Reset value 0. Cleared on END→FREE.
- Undefined: port absent. Divide-by-zero is indistinguishable from a genuine zero result.

Test Plan:
- Unsigned 100/7, start held → ready_o after 34 cycles; result_o = {32'd2, 32'd14}. Drop start → ready_o=0 and result_o=0 next cycle.
- Signed -7/2 (0xFFFFFFF9 / 0x2) → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Repeat with signed_div_i=0 → quotient 0x7FFFFFFC, remainder 0x1.
- Divisor 0, dividend 0x1234 → ready_o after 2 cycles, result_o=0. With DIV_ZERO_FLAG_EN: div_zero_o=1.
- Start 0xFFFFFFFF/3 unsigned, pulse annul_i at iteration 10 → back to FREE, ready_o never asserts. Next op 9/3 → result {0, 3} after 34 cycles.
- Signed 0x80000000/0xFFFFFFFF → result {0x00000000, 0x80000000}.
- Assert rst low asynchronously at iteration 20 → outputs 0 immediately. After release, 50/5 → {0, 10} after 34 cycles.

Source files
------------

// File: rtl/div_seq.sv
// div_seq: iterative radix-2 restoring divider (DIV/DIVU) producing {remainder, quotient} for HI/LO.
// Latency: 34 clk edges from the start-sampling edge (load + 32 steps + finalize); 2 edges on divide-by-zero.
// Backpressure: result and ready_o are held in END while start_i stays high; dropping start_i returns to FREE.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   start_i           divide request, held by EX until ready_o
//   annul_i           abort an operation in progress (flush/exception)
//   signed_div_i      1 = signed DIV, 0 = unsigned DIVU
//   opdata1_i/2_i     dividend / divisor, sampled only when leaving FREE
//   result_o          {remainder, quotient}, valid while ready_o is high
//   ready_o           result valid
//   div_zero_o        (only with DIV_ZERO_FLAG_EN defined) result came from a zero divisor
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_i,
    input  logic                 annul_i,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic                 div_zero_o
`endif
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    // Layout: [2W:W+1] partial remainder, [W:1] remaining dividend bits
    // shifting up, low bits collect quotient bits as the dividend shifts out.
    logic [2*WIDTH:0]    work_q;
    logic [WIDTH-1:0]    divisor_q;
    logic                qneg_q;
    logic                rneg_q;
    logic [2*WIDTH-1:0]  result_q;
    logic                ready_q;
`ifdef DIV_ZERO_FLAG_EN
    logic                div_zero_q;
`endif

    // Operand magnitudes for the load edge.
    logic                op1_neg;
    logic                op2_neg;
    logic [WIDTH-1:0]    op1_abs;
    logic [WIDTH-1:0]    op2_abs;

    assign op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign op1_abs = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    assign op2_abs = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    // Restoring step. The trial value (2*rem + next dividend bit) is below
    // 2*divisor, so a W+1 bit subtraction suffices: its MSB is the borrow.
    logic [WIDTH:0]      trial_d;
    logic                borrow_d;
    logic [2*WIDTH:0]    work_d;

    assign trial_d  = work_q[2*WIDTH:WIDTH] - {1'b0, divisor_q};
    assign borrow_d = trial_d[WIDTH];
    assign work_d   = borrow_d ? {work_q[2*WIDTH-1:0], 1'b0}
                               : {trial_d[WIDTH-1:0], work_q[WIDTH-1:0], 1'b1};

    // Finalize: remainder sits one position above its natural place because
    // the last step shifted it; take [2W:W+1] to undo that shift.
    logic [WIDTH-1:0]    quo_raw;
    logic [WIDTH-1:0]    rem_raw;
    logic [WIDTH-1:0]    quo_fin;
    logic [WIDTH-1:0]    rem_fin;

    assign quo_raw = work_q[WIDTH-1:0];
    assign rem_raw = work_q[2*WIDTH:WIDTH+1];
    // Negating 0x80000000 wraps to itself, giving the MIPS overflow result.
    assign quo_fin = qneg_q ? (~quo_raw + 1'b1) : quo_raw;
    assign rem_fin = rneg_q ? (~rem_raw + 1'b1) : rem_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_FREE;
            cnt_q      <= '0;
            work_q     <= '0;
            divisor_q  <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            div_zero_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_FREE: begin
                    ready_q  <= 1'b0;
                    result_q <= '0;
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_q <= 1'b0;
`endif
                    // annul has priority over a simultaneous start
                    if (start_i && !annul_i) begin
                        if (opdata2_i == '0) begin
                            state_q <= S_BYZERO;
                        end else begin
                            state_q   <= S_ON;
                            cnt_q     <= '0;
                            work_q    <= {{WIDTH{1'b0}}, op1_abs, 1'b0};
                            divisor_q <= op2_abs;
                            qneg_q    <= op1_neg ^ op2_neg;
                            rneg_q    <= op1_neg;
                        end
                    end
                end

                S_BYZERO: begin
                    state_q  <= S_END;
                    result_q <= '0;
                    ready_q  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    div_zero_q <= 1'b1;
`endif
                end

                S_ON: begin
                    if (annul_i) begin
                        state_q  <= S_FREE;
                        result_q <= '0;
                        ready_q  <= 1'b0;
                    end else if (cnt_q != CNT_W'(WIDTH)) begin
                        work_q <= work_d;
                        cnt_q  <= cnt_q + 1'b1;
                    end else begin
                        state_q  <= S_END;
                        result_q <= {rem_fin, quo_fin};
                        ready_q  <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_q <= 1'b0;
`endif
                    end
                end

                S_END: begin
                    if (!start_i) begin
                        state_q  <= S_FREE;
                        result_q <= '0;
                        ready_q  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                        div_zero_q <= 1'b0;
`endif
                    end
                end

                default: begin
                    state_q <= S_FREE;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
    assign div_zero_o = div_zero_q;
`endif

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed self-checking bench for div_seq.
// Latency: counts clock edges from the start-sampling edge to ready_o.
// Backpressure: holds start_i through END and checks outputs clear after it drops.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
`ifdef DIV_ZERO_FLAG_EN
    logic        div_zero_o;
`endif

    int total = 0;
    int bad   = 0;

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
`ifdef DIV_ZERO_FLAG_EN
        ,
        .div_zero_o   (div_zero_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one request and returns the edge count at which ready_o rose
    // (0 if it never did within the budget). Operands are scrambled after
    // the sampling edge, so a correct result proves they were latched.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                          output int cyc, output logic [63:0] res);
        @(negedge clk);
        opdata1_i    = a;
        opdata2_i    = b;
        signed_div_i = sgn;
        start_i      = 1'b1;
        cyc = 0;
        res = '0;
        for (int i = 1; i <= 100; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                opdata1_i = $urandom;
                opdata2_i = $urandom;
            end
            if (ready_o) begin
                cyc = i;
                res = result_o;
                break;
            end
        end
    endtask

    task automatic drop_start();
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b0) begin
            bad++; $display("FAIL reset_ready got=%b exp=0", ready_o);
        end
        total++;
        if (result_o !== 64'd0) begin
            bad++; $display("FAIL reset_result got=%h exp=0", result_o);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_unsigned_basic();
        int cyc;
        logic [63:0] res;
        run_op(32'd100, 32'd7, 1'b0, cyc, res);
        total++;
        if (cyc !== 34) begin
            bad++; $display("FAIL udiv_latency got=%0d exp=34", cyc);
        end
        total++;
        if (res !== {32'd2, 32'd14}) begin
            bad++; $display("FAIL udiv_100_7 got=%h exp=%h", res, {32'd2, 32'd14});
        end
        // start still high: result must be held
        @(posedge clk);
        #1;
        total++;
        if (ready_o !== 1'b1 || result_o !== {32'd2, 32'd14}) begin
            bad++; $display("FAIL udiv_hold got=%b/%h exp=1/%h", ready_o, result_o, {32'd2, 32'd14});
        end
`ifdef DIV_ZERO_FLAG_EN
        total++;
        if (div_zero_o !== 1'b0) begin
            bad++; $display("FAIL udiv_divzero_flag got=%b exp=0", div_zero_o);
        end
`endif
        drop_start();
        total++;
        if (ready_o !== 1'b0) begin
            bad++; $display("FAIL udiv_drop_ready got=%b exp=0", ready_o);
        end
        total++;
        if (result_o !== 64'd0) begin
            bad++; $display("FAIL udiv_drop_result got=%h exp=0", result_o);
        end
    endtask

    task automatic test_signed();
        int cyc;
        logic [63:0] res;
        run_op(32'hFFFF_FFF9, 32'h2, 1'b1, cyc, res);
        total++;
        if (res !== {32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
            bad++; $display("FAIL sdiv_m7_2 got=%h exp=%h", res, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        end
        drop_start();
        run_op(32'hFFFF_FFF9, 32'h2, 1'b0, cyc, res);
        total++;
        if (res !== {32'h1, 32'h7FFF_FFFC}) begin
            bad++; $display("FAIL udiv_fff9_2 got=%h exp=%h", res, {32'h1, 32'h7FFF_FFFC});
        end
        drop_start();
        // signed overflow wraps
        run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, cyc, res);
        total++;
        if (res !== {32'h0, 32'h8000_0000}) begin
            bad++; $display("FAIL sdiv_overflow got=%h exp=%h", res, {32'h0, 32'h8000_0000});
        end
        drop_start();
        // 7 / -2 signed: quotient -3, remainder +1 (follows dividend sign)
        run_op(32'd7, 32'hFFFF_FFFE, 1'b1, cyc, res);
        total++;
        if (res !== {32'h1, 32'hFFFF_FFFD}) begin
            bad++; $display("FAIL sdiv_7_m2 got=%h exp=%h", res, {32'h1, 32'hFFFF_FFFD});
        end
        drop_start();
        // divisor above 2^31 unsigned: remainder wider than 31 bits
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, cyc, res);
        total++;
        if (res !== {32'h1, 32'h1}) begin
            bad++; $display("FAIL udiv_big_divisor got=%h exp=%h", res, {32'h1, 32'h1});
        end
        drop_start();
    endtask

    task automatic test_div_zero();
        int cyc;
        logic [63:0] res;
        run_op(32'h1234, 32'h0, 1'b0, cyc, res);
        total++;
        if (cyc !== 2) begin
            bad++; $display("FAIL divzero_latency got=%0d exp=2", cyc);
        end
        total++;
        if (res !== 64'd0) begin
            bad++; $display("FAIL divzero_result got=%h exp=0", res);
        end
`ifdef DIV_ZERO_FLAG_EN
        total++;
        if (div_zero_o !== 1'b1) begin
            bad++; $display("FAIL divzero_flag got=%b exp=1", div_zero_o);
        end
`endif
        drop_start();
        total++;
        if (ready_o !== 1'b0) begin
            bad++; $display("FAIL divzero_drop_ready got=%b exp=0", ready_o);
        end
`ifdef DIV_ZERO_FLAG_EN
        total++;
        if (div_zero_o !== 1'b0) begin
            bad++; $display("FAIL divzero_flag_clear got=%b exp=0", div_zero_o);
        end
`endif
    endtask

    task automatic test_annul();
        int cyc;
        int seen;
        logic [63:0] res;
        @(negedge clk);
        opdata1_i    = 32'hFFFF_FFFF;
        opdata2_i    = 32'd3;
        signed_div_i = 1'b0;
        start_i      = 1'b1;
        repeat (11) @(posedge clk);     // load edge + 10 iterations
        @(negedge clk);
        annul_i = 1'b1;
        start_i = 1'b0;
        @(negedge clk);
        annul_i = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL annul_no_ready got=%0d exp=0", seen);
        end
        run_op(32'd9, 32'd3, 1'b0, cyc, res);
        total++;
        if (cyc !== 34) begin
            bad++; $display("FAIL after_annul_latency got=%0d exp=34", cyc);
        end
        total++;
        if (res !== {32'd0, 32'd3}) begin
            bad++; $display("FAIL after_annul_9_3 got=%h exp=%h", res, {32'd0, 32'd3});
        end
        drop_start();
    endtask

    task automatic test_annul_in_free();
        int seen;
        @(negedge clk);
        opdata1_i = 32'd10;
        opdata2_i = 32'd0;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if (ready_o) seen = 1;
        end
        total++;
        if (seen !== 0) begin
            bad++; $display("FAIL start_annul_free got=%0d exp=0", seen);
        end
        @(negedge clk);
        start_i = 1'b0;
        annul_i = 1'b0;
    endtask

    task automatic test_async_reset();
        int cyc;
        logic [63:0] res;
        // reset while a result is presented
        run_op(32'd50, 32'd5, 1'b0, cyc, res);
        #2 rst = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++; $display("FAIL reset_in_end got=%b/%h exp=0/0", ready_o, result_o);
        end
        @(negedge clk);
        start_i = 1'b0;
        rst     = 1'b1;
        // reset at iteration 20
        @(negedge clk);
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (21) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        total++;
        if (ready_o !== 1'b0 || result_o !== 64'd0) begin
            bad++; $display("FAIL reset_mid_op got=%b/%h exp=0/0", ready_o, result_o);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        run_op(32'd50, 32'd5, 1'b0, cyc, res);
        total++;
        if (cyc !== 34) begin
            bad++; $display("FAIL after_reset_latency got=%0d exp=34", cyc);
        end
        total++;
        if (res !== {32'd0, 32'd10}) begin
            bad++; $display("FAIL after_reset_50_5 got=%h exp=%h", res, {32'd0, 32'd10});
        end
        drop_start();
    endtask

    initial begin
        start_i      = 1'b0;
        annul_i      = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = '0;
        opdata2_i    = '0;
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_div_zero();
        test_annul();
        test_annul_in_free();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
